// File: rtl/control_pulses_pkg.sv
// Shared encodings for the AGC-style microsequencer: state codes, ALU ops and mux selects.
// State codes are fixed by the instruction set and must never be renumbered.
package control_pulses_pkg;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    S_TC      = 5'd0,
    S_CCS     = 5'd1,
    S_INDEX   = 5'd2,
    S_TS      = 5'd3,
    S_CA      = 5'd4,
    S_CS      = 5'd5,
    S_AD      = 5'd6,
    S_MASK    = 5'd7,
    S_XCH     = 5'd8,
    S_ADS     = 5'd9,
    S_MP      = 5'd10,
    S_EXTEND  = 5'd11,
    S_LOAD    = 5'd12,
    S_DXCH_LO = 5'd13,
    S_DXCH_HI = 5'd14,
    S_INIT    = 5'd30
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_COM  = 3'd3;
  localparam logic [2:0] ALU_MUL  = 3'd4;
  localparam logic [2:0] ALU_DABS = 3'd5;

  localparam logic [1:0] A_MUX_HOLD = 2'd0;
  localparam logic [1:0] A_MUX_ALU  = 2'd1;
  localparam logic [1:0] A_MUX_G    = 2'd2;

  localparam logic [1:0] Q_MUX_HOLD = 2'd0;
  localparam logic [1:0] Q_MUX_Z    = 2'd1;

  localparam logic [1:0] X_MUX_HOLD = 2'd0;
  localparam logic [1:0] X_MUX_A    = 2'd1;

  localparam logic [1:0] Z_MUX_INC  = 2'd0;
  localparam logic [1:0] Z_MUX_G    = 2'd1;
  localparam logic [1:0] Z_MUX_LP   = 2'd2;

  localparam logic [2:0] Y_MUX_HOLD = 3'd0;
  localparam logic [2:0] Y_MUX_G    = 3'd1;

endpackage

// File: rtl/control_pulses_seq_if.sv
// Instruction-field inputs and control-pulse outputs of the microsequencer.
// master = instruction register / datapath side, slave = sequencer.
interface control_pulses_seq_if;
  import control_pulses_pkg::*;

  logic [2:0]         opcode;
  logic [1:0]         qc;
  logic               extracode;

  logic               ext_flag;
  logic               mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr;
  logic               maddr_mux, mdata_mux, lp_mux, g_mux, b_mux;
  logic [1:0]         q_mux, a_mux, x_mux, z_mux;
  logic [2:0]         alu_op;
  logic [2:0]         y_mux;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    output opcode, qc, extracode,
    input  ext_flag, mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr,
    input  maddr_mux, mdata_mux, lp_mux, g_mux, b_mux,
    input  q_mux, a_mux, x_mux, z_mux, alu_op, y_mux, dbg_state
  );

  modport slave (
    input  opcode, qc, extracode,
    output ext_flag, mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr,
    output maddr_mux, mdata_mux, lp_mux, g_mux, b_mux,
    output q_mux, a_mux, x_mux, z_mux, alu_op, y_mux, dbg_state
  );
endinterface

// File: rtl/control_pulses_dispatch.sv
// Combinational instruction dispatch: opcode/qc/extracode -> first state of the instruction.
// MP via extracode exists only when CONTROL_PULSES_MP_EN is defined.
module control_pulses_dispatch
  import control_pulses_pkg::*;
(
  input  logic [2:0] opcode_i,
  input  logic [1:0] qc_i,
  input  logic       extracode_i,
  output state_e     next_o
);

`ifndef CONTROL_PULSES_MP_EN
  logic unused_extracode;
  assign unused_extracode = extracode_i;
`endif

  always_comb begin
    next_o = S_INIT;
    case (opcode_i)
      3'd0: next_o = S_TC;
      3'd1: next_o = S_CCS;
      3'd2: next_o = S_ADS;
      3'd3: next_o = S_CA;
      3'd4: next_o = S_CS;
      3'd5: begin
        case (qc_i)
          2'd0:    next_o = S_INDEX;
          2'd1:    next_o = S_LOAD;
          2'd2:    next_o = S_TS;
          2'd3:    next_o = S_XCH;
          default: next_o = S_INIT;
        endcase
      end
      3'd6: next_o = S_AD;
      3'd7: begin
`ifdef CONTROL_PULSES_MP_EN
        case (extracode_i)
          1'b1:    next_o = S_MP;
          1'b0:    next_o = S_MASK;
          default: next_o = S_INIT;
        endcase
`else
        next_o = S_MASK;
`endif
      end
      default: next_o = S_INIT;
    endcase
  end

endmodule

// File: rtl/control_pulses_seq.sv
// Microsequencer: 5-bit state register with Moore decode of control pulses.
// Optional macro CONTROL_PULSES_MP_EN enables the MP (extracode + opcode 7) state.
module control_pulses_seq
  import control_pulses_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  control_pulses_seq_if.slave bus
);

  state_e state_q, state_d;
  state_e dispatch_state;

  control_pulses_dispatch u_dispatch (
    .opcode_i    (bus.opcode),
    .qc_i        (bus.qc),
    .extracode_i (bus.extracode),
    .next_o      (dispatch_state)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // The LOAD/DXCH chain runs to EXTEND regardless of inputs; everything else dispatches.
  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_LOAD:    state_d = S_DXCH_LO;
      S_DXCH_LO: state_d = S_DXCH_HI;
      S_DXCH_HI: state_d = S_EXTEND;
      S_TC, S_CCS, S_INDEX, S_TS, S_CA, S_CS, S_AD, S_MASK,
      S_XCH, S_ADS, S_EXTEND, S_INIT:
        state_d = dispatch_state;
`ifdef CONTROL_PULSES_MP_EN
      S_MP:      state_d = dispatch_state;
`endif
      default:   state_d = S_INIT;
    endcase
  end

  always_comb begin
    bus.ext_flag  = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.lp_wr     = 1'b0;
    bus.g_wr      = 1'b0;
    bus.q_wr      = 1'b0;
    bus.b_wr      = 1'b0;
    bus.a_wr      = 1'b0;
    bus.y_wr      = 1'b0;
    bus.x_wr      = 1'b0;
    bus.z_wr      = 1'b0;
    bus.maddr_mux = 1'b0;
    bus.mdata_mux = 1'b0;
    bus.lp_mux    = 1'b0;
    bus.g_mux     = 1'b0;
    bus.b_mux     = 1'b0;
    bus.q_mux     = Q_MUX_HOLD;
    bus.a_mux     = A_MUX_HOLD;
    bus.x_mux     = X_MUX_HOLD;
    bus.z_mux     = Z_MUX_INC;
    bus.alu_op    = ALU_PASS;
    bus.y_mux     = Y_MUX_HOLD;
    case (state_q)
      S_TC: begin
        bus.q_wr = 1'b1; bus.q_mux = Q_MUX_Z;
        bus.z_wr = 1'b1; bus.z_mux = Z_MUX_G;
      end
      S_CCS: begin
        bus.x_wr = 1'b1; bus.x_mux = X_MUX_A;
        bus.alu_op = ALU_DABS;
        bus.a_wr = 1'b1; bus.a_mux = A_MUX_ALU;
      end
      S_INDEX: begin
        bus.b_wr = 1'b1; bus.b_mux = 1'b1;
      end
      S_TS: begin
        bus.mem_wr = 1'b1; bus.mdata_mux = 1'b1; bus.maddr_mux = 1'b1;
      end
      S_CA: begin
        bus.g_wr = 1'b1;
        bus.a_wr = 1'b1; bus.a_mux = A_MUX_G;
      end
      S_CS: begin
        bus.g_wr = 1'b1;
        bus.alu_op = ALU_COM;
        bus.a_wr = 1'b1; bus.a_mux = A_MUX_ALU;
      end
      S_AD, S_ADS, S_MASK: begin
        bus.x_wr = 1'b1;
        bus.y_wr = 1'b1; bus.y_mux = Y_MUX_G;
        bus.a_wr = 1'b1; bus.a_mux = A_MUX_ALU;
        bus.alu_op = (state_q == S_MASK) ? ALU_AND : ALU_ADD;
        bus.mem_wr = (state_q == S_ADS);
      end
`ifdef CONTROL_PULSES_MP_EN
      S_MP: begin
        bus.x_wr = 1'b1;
        bus.y_wr = 1'b1; bus.y_mux = Y_MUX_G;
        bus.a_wr = 1'b1; bus.a_mux = A_MUX_ALU;
        bus.alu_op = ALU_MUL;
      end
`endif
      S_XCH: begin
        bus.g_wr = 1'b1; bus.g_mux = 1'b1;
        bus.a_wr = 1'b1; bus.a_mux = A_MUX_G;
        bus.mem_wr = 1'b1;
      end
      S_LOAD: begin
        bus.g_wr = 1'b1; bus.maddr_mux = 1'b1;
      end
      S_DXCH_LO: begin
        bus.lp_wr = 1'b1; bus.lp_mux = 1'b1;
        bus.mem_wr = 1'b1;
      end
      S_DXCH_HI: begin
        bus.a_wr = 1'b1; bus.a_mux = A_MUX_G;
        bus.z_wr = 1'b1; bus.z_mux = Z_MUX_LP;
      end
      S_EXTEND: begin
        bus.ext_flag = 1'b1;
        bus.z_wr = 1'b1; bus.z_mux = Z_MUX_INC;
      end
      default: ;
    endcase
  end

  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_control_pulses_seq.sv
// Directed bench for control_pulses_seq; expected states and pulses are hand-derived.
// Build with CONTROL_PULSES_MP_EN defined to exercise the MP dispatch path.
module tb_control_pulses_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  control_pulses_seq_if bus ();

  control_pulses_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of every control output, fixed field order.
  logic [28:0] obs;
  assign obs = {bus.ext_flag, bus.mem_wr, bus.lp_wr, bus.g_wr, bus.q_wr, bus.b_wr,
                bus.a_wr, bus.y_wr, bus.x_wr, bus.z_wr,
                bus.maddr_mux, bus.mdata_mux, bus.lp_mux, bus.g_mux, bus.b_mux,
                bus.q_mux, bus.a_mux, bus.x_mux, bus.z_mux, bus.alu_op, bus.y_mux};

  // Reference pulse table transcribed from the instruction definitions.
  function automatic logic [28:0] exp_ctl(input logic [4:0] st);
    logic ext, mw, lpw, gw, qw, bw, aw, yw, xw, zw, mam, mdm, lpm, gm, bm;
    logic [1:0] qm, am, xm, zm;
    logic [2:0] alu, ym;
    {ext, mw, lpw, gw, qw, bw, aw, yw, xw, zw, mam, mdm, lpm, gm, bm,
     qm, am, xm, zm, alu, ym} = '0;
    case (st)
      5'd0:  begin qw = 1; qm = 2'd1; zw = 1; zm = 2'd1; end
      5'd1:  begin xw = 1; xm = 2'd1; alu = 3'd5; aw = 1; am = 2'd1; end
      5'd2:  begin bw = 1; bm = 1; end
      5'd3:  begin mw = 1; mdm = 1; mam = 1; end
      5'd4:  begin gw = 1; aw = 1; am = 2'd2; end
      5'd5:  begin gw = 1; alu = 3'd3; aw = 1; am = 2'd1; end
      5'd6:  begin xw = 1; yw = 1; ym = 3'd1; aw = 1; am = 2'd1; alu = 3'd1; end
      5'd7:  begin xw = 1; yw = 1; ym = 3'd1; aw = 1; am = 2'd1; alu = 3'd2; end
      5'd8:  begin gw = 1; gm = 1; aw = 1; am = 2'd2; mw = 1; end
      5'd9:  begin xw = 1; yw = 1; ym = 3'd1; aw = 1; am = 2'd1; alu = 3'd1; mw = 1; end
`ifdef CONTROL_PULSES_MP_EN
      5'd10: begin xw = 1; yw = 1; ym = 3'd1; aw = 1; am = 2'd1; alu = 3'd4; end
`endif
      5'd11: begin ext = 1; zw = 1; zm = 2'd0; end
      5'd12: begin gw = 1; mam = 1; end
      5'd13: begin lpw = 1; lpm = 1; mw = 1; end
      5'd14: begin aw = 1; am = 2'd2; zw = 1; zm = 2'd2; end
      default: ;
    endcase
    return {ext, mw, lpw, gw, qw, bw, aw, yw, xw, zw, mam, mdm, lpm, gm, bm,
            qm, am, xm, zm, alu, ym};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.opcode = 3'd0; bus.qc = 2'd0; bus.extracode = 1'b0;
    step();
    checks++;
    if (bus.dbg_state !== 5'd30) begin
      errors++; $display("FAIL reset_state: got %0d exp 30", bus.dbg_state);
    end
    checks++;
    if (obs !== 29'd0) begin
      errors++; $display("FAIL reset_outputs: got %h exp 0", obs);
    end
  endtask

  task automatic test_mask_hold();
    rst_n = 1'b1; bus.opcode = 3'd7; bus.qc = 2'd0; bus.extracode = 1'b0;
    step();
    checks++;
    if (bus.dbg_state !== 5'd7) begin
      errors++; $display("FAIL mask_state: got %0d exp 7", bus.dbg_state);
    end
    checks++;
    if (bus.alu_op !== 3'd2 || bus.a_wr !== 1'b1) begin
      errors++; $display("FAIL mask_pulses: alu_op %0d a_wr %0b exp 2 1", bus.alu_op, bus.a_wr);
    end
    checks++;
    if (obs !== exp_ctl(5'd7)) begin
      errors++; $display("FAIL mask_outputs: got %h exp %h", obs, exp_ctl(5'd7));
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.dbg_state !== 5'd7) begin
        errors++; $display("FAIL mask_hold cycle %0d: got %0d exp 7", i, bus.dbg_state);
      end
    end
  endtask

  task automatic test_load_chain();
    logic [4:0] exp_st [4];
    exp_st = '{5'd12, 5'd13, 5'd14, 5'd11};
    bus.opcode = 3'd5; bus.qc = 2'd1; bus.extracode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      // Inputs after the first edge must not disturb the chain.
      bus.opcode = 3'd0; bus.qc = 2'd0;
      checks++;
      if (bus.dbg_state !== exp_st[i]) begin
        errors++; $display("FAIL chain_state edge %0d: got %0d exp %0d", i + 1, bus.dbg_state, exp_st[i]);
      end
      checks++;
      if (obs !== exp_ctl(exp_st[i])) begin
        errors++; $display("FAIL chain_outputs edge %0d: got %h exp %h", i + 1, obs, exp_ctl(exp_st[i]));
      end
    end
    checks++;
    if (bus.ext_flag !== 1'b1) begin
      errors++; $display("FAIL chain_ext_flag: got %0b exp 1", bus.ext_flag);
    end
    step();
    checks++;
    if (bus.dbg_state !== 5'd0) begin
      errors++; $display("FAIL chain_resume: got %0d exp 0", bus.dbg_state);
    end
  endtask

  task automatic test_dispatch();
    logic [2:0] op_t [9];
    logic [1:0] qc_t [9];
    logic [4:0] st_t [9];
    op_t = '{3'd5, 3'd5, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    qc_t = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    st_t = '{5'd2, 5'd3, 5'd8, 5'd0, 5'd1, 5'd9, 5'd4, 5'd5, 5'd6};
    bus.extracode = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.opcode = op_t[i]; bus.qc = qc_t[i];
      step();
      checks++;
      if (bus.dbg_state !== st_t[i]) begin
        errors++; $display("FAIL dispatch_state op %0d qc %0d: got %0d exp %0d", op_t[i], qc_t[i], bus.dbg_state, st_t[i]);
      end
      checks++;
      if (obs !== exp_ctl(st_t[i])) begin
        errors++; $display("FAIL dispatch_outputs state %0d: got %h exp %h", st_t[i], obs, exp_ctl(st_t[i]));
      end
    end
  endtask

  task automatic test_mp();
    logic [4:0] exp_st;
    logic [2:0] exp_alu;
`ifdef CONTROL_PULSES_MP_EN
    exp_st = 5'd10; exp_alu = 3'd4;
`else
    exp_st = 5'd7; exp_alu = 3'd2;
`endif
    bus.opcode = 3'd7; bus.qc = 2'd0; bus.extracode = 1'b1;
    step();
    checks++;
    if (bus.dbg_state !== exp_st) begin
      errors++; $display("FAIL mp_state: got %0d exp %0d", bus.dbg_state, exp_st);
    end
    checks++;
    if (bus.alu_op !== exp_alu) begin
      errors++; $display("FAIL mp_alu_op: got %0d exp %0d", bus.alu_op, exp_alu);
    end
    checks++;
    if (obs !== exp_ctl(exp_st)) begin
      errors++; $display("FAIL mp_outputs: got %h exp %h", obs, exp_ctl(exp_st));
    end
    bus.extracode = 1'b0;
    step();
    checks++;
    if (bus.dbg_state !== 5'd7) begin
      errors++; $display("FAIL mp_to_mask: got %0d exp 7", bus.dbg_state);
    end
  endtask

  task automatic test_reset_mid_chain();
    bus.opcode = 3'd5; bus.qc = 2'd1; bus.extracode = 1'b0;
    step();
    step();
    checks++;
    if (bus.dbg_state !== 5'd13) begin
      errors++; $display("FAIL midreset_setup: got %0d exp 13", bus.dbg_state);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.dbg_state !== 5'd30) begin
      errors++; $display("FAIL midreset_state: got %0d exp 30", bus.dbg_state);
    end
    checks++;
    if (obs !== 29'd0) begin
      errors++; $display("FAIL midreset_outputs: got %h exp 0", obs);
    end
    rst_n = 1'b1; bus.opcode = 3'd3; bus.qc = 2'd0;
    step();
    checks++;
    if (bus.dbg_state !== 5'd4) begin
      errors++; $display("FAIL midreset_resume: got %0d exp 4", bus.dbg_state);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.opcode = 3'd0; bus.qc = 2'd0; bus.extracode = 1'b0;
    test_reset();
    test_mask_hold();
    test_load_chain();
    test_dispatch();
    test_mp();
    test_reset_mid_chain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
